// File: rtl/txn_sched_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | txn_sched_arb: weighted round-robin merge of N_REQ valid/ready streams      |
// | into one registered transaction output.                    Rev 1.0          |
// +----------------------------------------------------------------------------+
module txn_sched_arb #(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WEIGHT_W       = 4,
  parameter int DEFAULT_WEIGHT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           req_kind,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic                       cfg_load,
  input  logic [N_REQ*WEIGHT_W-1:0]  cfg_weight,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_kind,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  output logic                       busy
);

  localparam int                  SRC_W  = $clog2(N_REQ);
  localparam logic [SRC_W:0]      NREQ_X = (SRC_W+1)'(N_REQ);
  localparam logic [SRC_W-1:0]    LAST   = SRC_W'(N_REQ-1);
  localparam logic [WEIGHT_W-1:0] W_RST  = WEIGHT_W'(DEFAULT_WEIGHT);

  typedef enum logic [0:0] {ARB = 1'b0, REFILL = 1'b1} state_t;

  state_t              state;
  logic [WEIGHT_W-1:0] w [N_REQ];
  logic [WEIGHT_W-1:0] c [N_REQ];
  logic [SRC_W-1:0]    ptr;
  logic [SRC_W-1:0]    winner;
  logic [SRC_W:0]      idx;
  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    enabled;
  logic [N_REQ-1:0]    elig_after;
  logic                slot_free;
  logic                any_elig;
  logic                grant;

  always_comb begin
    eligible = '0;
    enabled  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (c[i] != '0);
      enabled[i]  = req_valid[i] && (w[i] != '0);
    end
  end

  assign slot_free = !out_valid || out_ready;

  // Rotating search starting at ptr; first eligible index wins.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (SRC_W+1)'(k);
      if (idx >= NREQ_X) idx = idx - NREQ_X;
      if (!any_elig && eligible[idx[SRC_W-1:0]]) begin
        any_elig = 1'b1;
        winner   = idx[SRC_W-1:0];
      end
    end
  end

  assign grant = !rst && (state == ARB) && slot_free && any_elig;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Eligibility as it will stand once this cycle's grant has spent its credit.
  // Entering REFILL straight from the exhausting grant keeps each refill
  // round down to a single bubble cycle.
  always_comb begin
    elig_after = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_after[i] = req_valid[i] &&
                      (c[i] != WEIGHT_W'(grant && (winner == SRC_W'(i))));
    end
  end

  assign busy = out_valid || (|enabled);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_kind  <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_src   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        w[i] <= W_RST;
        c[i] <= W_RST;
      end
    end else begin
      if (out_ready) out_valid <= 1'b0;

      case (state)
        ARB: begin
          if (grant) begin
            out_valid <= 1'b1;
            out_kind  <= req_kind[winner];
            out_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            out_data  <= req_data[int'(winner)*DATA_W +: DATA_W];
            out_src   <= winner;
            c[winner] <= c[winner] - 1'b1;
            ptr       <= (winner == LAST) ? '0 : winner + 1'b1;
            if (!(|elig_after) && (|enabled)) state <= REFILL;
          end else if (slot_free && (|enabled)) begin
            state <= REFILL;
          end
        end
        REFILL: begin
          for (int i = 0; i < N_REQ; i++) c[i] <= w[i];
          state <= ARB;
        end
        default: state <= ARB;
      endcase

      // Reload wins over any same-cycle credit decrement or refill.
      if (cfg_load) begin
        for (int i = 0; i < N_REQ; i++) begin
          w[i] <= cfg_weight[i*WEIGHT_W +: WEIGHT_W];
          c[i] <= cfg_weight[i*WEIGHT_W +: WEIGHT_W];
        end
        ptr   <= '0;
        state <= ARB;
      end
    end
  end

endmodule
`default_nettype wire
